// File: rtl/cacheline_adapter_if.sv
// Bus bundles around the cache-line adapter: the cache-facing line port (dfp)
// and the burst-memory beat port (bmem).

interface cacheline_adapter_dfp_if #(
   parameter int LINE_WIDTH = 256
);
   logic [31:0]           dfp_addr;
   logic                  dfp_read;
   logic                  dfp_write;
   logic [LINE_WIDTH-1:0] dfp_wdata;
   logic [LINE_WIDTH-1:0] dfp_rdata;
   logic                  dfp_resp;

   // The cache drives requests; the adapter answers with the line and a pulse.
   modport master (
      output dfp_addr, dfp_read, dfp_write, dfp_wdata,
      input  dfp_rdata, dfp_resp
   );

   modport slave (
      input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
      output dfp_rdata, dfp_resp
   );
endinterface

interface cacheline_adapter_bmem_if #(
   parameter int BUS_WIDTH = 64
);
   logic [31:0]          bmem_addr;
   logic                 bmem_read;
   logic                 bmem_write;
   logic [BUS_WIDTH-1:0] bmem_wdata;
   logic                 bmem_ready;
   logic [31:0]          bmem_raddr;
   logic [BUS_WIDTH-1:0] bmem_rdata;
   logic                 bmem_rvalid;

   // The adapter issues bursts; memory accepts them and returns tagged read beats.
   modport master (
      output bmem_addr, bmem_read, bmem_write, bmem_wdata,
      input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
   );

   modport slave (
      input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
      output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
   );
endinterface

// File: rtl/cacheline_adapter.sv
// Splits cache-line reads and writebacks into fixed-length bursts of bus beats
// and reassembles returning read beats into a full line.

module cacheline_adapter #(
   parameter int LINE_WIDTH = 256,
   parameter int BUS_WIDTH  = 64
) (
   input logic                      clk,
   input logic                      rst,
   cacheline_adapter_dfp_if.slave   dfp,
   cacheline_adapter_bmem_if.master bmem
);

   localparam int BEATS       = LINE_WIDTH / BUS_WIDTH;
   localparam int CNT_W       = $clog2(BEATS);
   localparam int BEAT_SH     = $clog2(BUS_WIDTH);
   localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
   localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_BEATS,
      WR_BEATS,
      RESP
   } state_e;

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic [31:0]             addr_q;
   logic [LINE_WIDTH-1:0]   line_q;
   logic [LINE_WIDTH-1:0]   rdata_q;
   logic [BUS_WIDTH-1:0]    wdata_q;
   logic                    read_q;
   logic                    write_q;
   logic                    resp_q;

   logic                    lastBeat;
   logic                    beatHit;
   logic [CNT_W+BEAT_SH-1:0] rdIdx;
   logic [CNT_W+BEAT_SH-1:0] wrIdx;

   // Beat slots are power-of-two aligned, so a slot offset is just the count shifted.
   assign cnt_d    = cnt_q + 1'b1;
   assign lastBeat = (cnt_q == CNT_W'(BEATS - 1));
   assign beatHit  = bmem.bmem_rvalid && (bmem.bmem_raddr == addr_q);
   assign rdIdx    = {cnt_q, BEAT_SH'(0)};
   assign wrIdx    = {cnt_d, BEAT_SH'(0)};

   // Whole transfer sequencer; every bus-facing output comes straight from a flop.
   // The next write beat is preloaded as the current one is consumed so the
   // data is already stable when the memory stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         line_q  <= '0;
         rdata_q <= '0;
         wdata_q <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         resp_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (dfp.dfp_write) begin
                  addr_q  <= dfp.dfp_addr & ADDR_MASK;
                  line_q  <= dfp.dfp_wdata;
                  wdata_q <= dfp.dfp_wdata[BUS_WIDTH-1:0];
                  cnt_q   <= '0;
                  write_q <= 1'b1;
                  state_q <= WR_BEATS;
               end else if (dfp.dfp_read) begin
                  addr_q  <= dfp.dfp_addr & ADDR_MASK;
                  read_q  <= 1'b1;
                  state_q <= RD_REQ;
               end
            end
            RD_REQ: begin
               if (bmem.bmem_ready) begin
                  read_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= RD_BEATS;
               end
            end
            RD_BEATS: begin
               if (beatHit) begin
                  rdata_q[rdIdx +: BUS_WIDTH] <= bmem.bmem_rdata;
                  cnt_q <= cnt_d;
                  if (lastBeat) begin
                     resp_q  <= 1'b1;
                     state_q <= RESP;
                  end
               end
            end
            WR_BEATS: begin
               if (bmem.bmem_ready) begin
                  cnt_q <= cnt_d;
                  if (lastBeat) begin
                     write_q <= 1'b0;
                     resp_q  <= 1'b1;
                     state_q <= RESP;
                  end else begin
                     wdata_q <= line_q[wrIdx +: BUS_WIDTH];
                  end
               end
            end
            RESP: begin
               resp_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dfp.dfp_rdata   = rdata_q;
   assign dfp.dfp_resp    = resp_q;
   assign bmem.bmem_addr  = addr_q;
   assign bmem.bmem_read  = read_q;
   assign bmem.bmem_write = write_q;
   assign bmem.bmem_wdata = wdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: stimulus queues expected bus beats,
// read requests and completions; a forked monitor pops and compares them.

module tb_cacheline_adapter;

   localparam int LW = 256;
   localparam int BW = 64;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   logic rstQ;

   always #5 clk = ~clk;

   // Cycle index and a delayed copy of reset, so the monitor knows when reset took effect.
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      rstQ <= rst;
   end

   cacheline_adapter_dfp_if  #(.LINE_WIDTH(LW)) dfp ();
   cacheline_adapter_bmem_if #(.BUS_WIDTH(BW))  bmem ();

   cacheline_adapter #(.LINE_WIDTH(LW), .BUS_WIDTH(BW)) dut (
      .clk  (clk),
      .rst  (rst),
      .dfp  (dfp),
      .bmem (bmem)
   );

   typedef struct {
      logic [31:0] addr;
      int          cyc;
   } rdReqT;

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
   } wrBeatT;

   typedef struct {
      logic          isRead;
      logic [255:0]  line;
      int            cyc;
   } respT;

   rdReqT  rdReqQ[$];
   wrBeatT wrBeatQ[$];
   respT   respQ[$];

   int   checks = 0;
   int   errors = 0;
   logic expectZeroRdata = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [255:0] wdata);
      dfp.dfp_read  = rd;
      dfp.dfp_write = wr;
      dfp.dfp_addr  = addr;
      dfp.dfp_wdata = wdata;
   endtask

   task automatic pushWriteLine(input logic [31:0] addr, input logic [255:0] line);
      for (int i = 0; i < 4; i++) wrBeatQ.push_back('{addr: addr, data: line[64*i +: 64]});
   endtask

   // Drives four matching read beats back to back; optionally one foreign-address beat after beat strayAfter.
   task automatic driveBeats(input logic [31:0] addr, input logic [255:0] line, input int strayAfter);
      for (int i = 0; i < 4; i++) begin
         bmem.bmem_rvalid = 1'b1;
         bmem.bmem_raddr  = addr;
         bmem.bmem_rdata  = line[64*i +: 64];
         tick();
         if (i == strayAfter) begin
            bmem.bmem_raddr = addr ^ 32'h0000_0100;
            bmem.bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            tick();
         end
      end
      bmem.bmem_rvalid = 1'b0;
   endtask

   task automatic waitResp(input int budget);
      int n = 0;
      while (dfp.dfp_resp !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      checkOutput("resp_seen", 256'(dfp.dfp_resp), 256'(1));
   endtask

   // Compares every observable DUT event against the head of the matching queue.
   task automatic monitor();
      logic        prevStall = 1'b0;
      logic        prevResp  = 1'b0;
      logic [31:0] prevAddr  = '0;
      logic [63:0] prevData  = '0;
      rdReqT       rq;
      wrBeatT      wb;
      respT        rs;
      forever begin
         @(negedge clk);
         if (rstQ === 1'b1) begin
            checkOutput("rst_resp",  256'(dfp.dfp_resp),   256'(0));
            checkOutput("rst_read",  256'(bmem.bmem_read),  256'(0));
            checkOutput("rst_write", 256'(bmem.bmem_write), 256'(0));
            checkOutput("rst_rdata", dfp.dfp_rdata, '0);
            prevStall = 1'b0;
            prevResp  = 1'b0;
         end else begin
            if (expectZeroRdata) checkOutput("rdata_zero", dfp.dfp_rdata, '0);
            if (bmem.bmem_read === 1'b1 || bmem.bmem_write === 1'b1)
               checkOutput("rd_wr_excl", 256'(bmem.bmem_read & bmem.bmem_write), 256'(0));
            if (prevStall) begin
               checkOutput("wr_hold_valid", 256'(bmem.bmem_write), 256'(1));
               checkOutput("wr_hold_data",  256'(bmem.bmem_wdata), 256'(prevData));
               checkOutput("wr_hold_addr",  256'(bmem.bmem_addr),  256'(prevAddr));
            end
            if (bmem.bmem_read === 1'b1 && bmem.bmem_ready === 1'b1) begin
               checkOutput("rdreq_expected", 256'(rdReqQ.size() > 0), 256'(1));
               if (rdReqQ.size() > 0) begin
                  rq = rdReqQ.pop_front();
                  checkOutput("rdreq_addr",  256'(bmem.bmem_addr), 256'(rq.addr));
                  checkOutput("rdreq_cycle", 256'(cyc), 256'(rq.cyc));
               end
            end
            if (bmem.bmem_write === 1'b1 && bmem.bmem_ready === 1'b1) begin
               checkOutput("wrbeat_expected", 256'(wrBeatQ.size() > 0), 256'(1));
               if (wrBeatQ.size() > 0) begin
                  wb = wrBeatQ.pop_front();
                  checkOutput("wrbeat_addr", 256'(bmem.bmem_addr),  256'(wb.addr));
                  checkOutput("wrbeat_data", 256'(bmem.bmem_wdata), 256'(wb.data));
               end
            end
            if (dfp.dfp_resp === 1'b1) begin
               checkOutput("resp_single", 256'(prevResp), 256'(0));
               checkOutput("resp_expected", 256'(respQ.size() > 0), 256'(1));
               if (respQ.size() > 0) begin
                  rs = respQ.pop_front();
                  checkOutput("resp_cycle", 256'(cyc), 256'(rs.cyc));
                  if (rs.isRead) checkOutput("resp_rdata", dfp.dfp_rdata, rs.line);
               end
            end
            prevStall = (bmem.bmem_write === 1'b1) && (bmem.bmem_ready !== 1'b1);
            prevAddr  = bmem.bmem_addr;
            prevData  = bmem.bmem_wdata;
            prevResp  = (dfp.dfp_resp === 1'b1);
         end
      end
   endtask

   initial begin
      int c;
      logic [255:0] lineA;
      logic [255:0] lineW;
      logic [255:0] lineB;
      logic [255:0] lineC;
      lineA = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      lineW = {64'hD3D3_0003_3333_D3D3, 64'hD2D2_0002_2222_D2D2,
               64'hD1D1_0001_1111_D1D1, 64'hD0D0_0000_0000_D0D0};
      lineB = {64'hBBBB_0000_0000_0004, 64'hBBBB_0000_0000_0003,
               64'hBBBB_0000_0000_0002, 64'hBBBB_0000_0000_0001};
      lineC = {64'hCCCC_CCCC_0000_0004, 64'hCCCC_CCCC_0000_0003,
               64'hCCCC_CCCC_0000_0002, 64'hCCCC_CCCC_0000_0001};

      // Reset with a pending read and a valid read beat on the bus.
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0000_0000, '0);
      bmem.bmem_ready  = 1'b1;
      bmem.bmem_rvalid = 1'b1;
      bmem.bmem_raddr  = 32'h0000_0000;
      bmem.bmem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
      fork
         monitor();
      join_none
      tick();
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0000_0000, '0);
      bmem.bmem_rvalid = 1'b0;
      expectZeroRdata  = 1'b1;
      tick();
      tick();
      expectZeroRdata  = 1'b0;

      // Line read with a stray matching beat during RD_REQ and beats from cycle 4.
      $display("[TB] read line");
      c = cyc;
      applyStimulus(1'b1, 1'b0, 32'h0000_1234, '0);
      rdReqQ.push_back('{addr: 32'h0000_1220, cyc: c + 1});
      respQ.push_back('{isRead: 1'b1, line: lineA, cyc: c + 8});
      tick();
      bmem.bmem_rvalid = 1'b1;
      bmem.bmem_raddr  = 32'h0000_1220;
      bmem.bmem_rdata  = 64'hEEEE_EEEE_EEEE_EEEE;
      tick();
      bmem.bmem_rvalid = 1'b0;
      tick();
      tick();
      driveBeats(32'h0000_1220, lineA, -1);
      waitResp(20);
      applyStimulus(1'b0, 1'b0, 32'h0, '0);
      tick();

      // Line write with one stall while beat 0 is presented.
      $display("[TB] write line");
      c = cyc;
      applyStimulus(1'b0, 1'b1, 32'h8000_0040, lineW);
      pushWriteLine(32'h8000_0040, lineW);
      respQ.push_back('{isRead: 1'b0, line: '0, cyc: c + 6});
      tick();
      bmem.bmem_ready = 1'b0;
      tick();
      bmem.bmem_ready = 1'b1;
      waitResp(20);
      applyStimulus(1'b0, 1'b0, 32'h0, '0);
      tick();

      // Writeback, then the cache switches to the allocate read the cycle after RESP.
      $display("[TB] writeback then allocate");
      c = cyc;
      applyStimulus(1'b0, 1'b1, 32'h0000_2000, lineW);
      pushWriteLine(32'h0000_2000, lineW);
      respQ.push_back('{isRead: 1'b0, line: '0, cyc: c + 5});
      rdReqQ.push_back('{addr: 32'h0000_3000, cyc: c + 7});
      respQ.push_back('{isRead: 1'b1, line: lineB, cyc: c + 12});
      waitResp(20);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0000_3000, lineW);
      tick();
      tick();
      driveBeats(32'h0000_3000, lineB, -1);
      waitResp(20);
      applyStimulus(1'b0, 1'b0, 32'h0, '0);
      tick();

      // Read and write together: write first, then the still-held read, with a stray beat.
      $display("[TB] simultaneous request and stray beat");
      c = cyc;
      applyStimulus(1'b1, 1'b1, 32'h0000_4008, lineB);
      pushWriteLine(32'h0000_4000, lineB);
      respQ.push_back('{isRead: 1'b0, line: '0, cyc: c + 5});
      rdReqQ.push_back('{addr: 32'h0000_4000, cyc: c + 7});
      respQ.push_back('{isRead: 1'b1, line: lineC, cyc: c + 13});
      waitResp(20);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0000_4008, lineB);
      tick();
      tick();
      driveBeats(32'h0000_4000, lineC, 1);
      waitResp(20);
      applyStimulus(1'b0, 1'b0, 32'h0, '0);
      tick();

      // Reset after two beats; the remaining beats arrive afterwards and must be ignored.
      $display("[TB] reset mid-read");
      c = cyc;
      applyStimulus(1'b1, 1'b0, 32'h0000_501F, '0);
      rdReqQ.push_back('{addr: 32'h0000_5000, cyc: c + 1});
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         bmem.bmem_rvalid = 1'b1;
         bmem.bmem_raddr  = 32'h0000_5000;
         bmem.bmem_rdata  = lineA[64*i +: 64];
         tick();
      end
      bmem.bmem_rvalid = 1'b0;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, '0);
      tick();
      rst = 1'b0;
      expectZeroRdata = 1'b1;
      for (int i = 2; i < 4; i++) begin
         bmem.bmem_rvalid = 1'b1;
         bmem.bmem_raddr  = 32'h0000_5000;
         bmem.bmem_rdata  = lineA[64*i +: 64];
         tick();
      end
      bmem.bmem_rvalid = 1'b0;
      tick();
      tick();
      checkOutput("post_rst_resp", 256'(dfp.dfp_resp), 256'(0));
      expectZeroRdata = 1'b0;

      // A fresh read after the abandoned one proves the FSM restarted from IDLE.
      c = cyc;
      applyStimulus(1'b1, 1'b0, 32'h0000_6000, '0);
      rdReqQ.push_back('{addr: 32'h0000_6000, cyc: c + 1});
      respQ.push_back('{isRead: 1'b1, line: lineA, cyc: c + 6});
      tick();
      tick();
      driveBeats(32'h0000_6000, lineA, -1);
      waitResp(20);
      applyStimulus(1'b0, 1'b0, 32'h0, '0);
      repeat (4) tick();

      checkOutput("rdreq_left",  256'(rdReqQ.size()),  256'(0));
      checkOutput("wrbeat_left", 256'(wrBeatQ.size()), 256'(0));
      checkOutput("resp_left",   256'(respQ.size()),   256'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
